song_sequencer: RTL and testbench

//   Controller between the piano front-end and the tone generator.

---
 rtl/song_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_song_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: piano front-end controller. Free play from the keys, automatic song
// playback from an external synchronous ROM, and a learn mode that waits for the correct key.
module song_sequencer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int NUM_SONGS   = 4,
   parameter int SONG_LEN    = 64,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        mode,
   input  logic [6:0]        keys,
   input  logic [1:0]        song_select,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [9:0]        rom_data,
   output logic [3:0]        note_out,
   output logic [1:0]        octave_auto,
   output logic [6:0]        led_out,
   output logic [1:0]        song_idx,
   output logic              busy
);

   localparam logic [2:0] MODE_FREE  = 3'b100;
   localparam logic [2:0] MODE_AUTO  = 3'b010;
   localparam logic [2:0] MODE_LEARN = 3'b001;

   localparam int CNT_MAX = (15 * BEAT_CYCLES > GAP_CYCLES) ? 15 * BEAT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_ROM,
      S_WAIT_KEY,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   // Lowest pressed key wins; key bit i is note i+1.
   function automatic logic [3:0] prio_note(input logic [6:0] k);
      logic [3:0] p;
      p = 4'd0;
      for (int i = 6; i >= 0; i--) begin
         if (k[i]) p = 4'(i + 1);
      end
      return p;
   endfunction

   function automatic logic [6:0] note_led(input logic [3:0] n);
      if (n == 4'd0 || n > 4'd7) return 7'd0;
      return 7'd1 << (n - 4'd1);
   endfunction

   state_t            state, state_nxt;
   logic [2:0]        mode_q;
   logic [6:0]        keys_q, key_rise;
   logic [1:0]        sel_q, sel_rise;
   logic [1:0]        song_idx_nxt;
   logic              song_chg;
   logic              mode_run, mode_q_run, mode_chg, key_hit, free_on;
   logic [9:0]        word_q, word_nxt;
   logic [CNT_W-1:0]  cnt, play_len;
   logic [ADDR_W-1:0] base_nxt, slot_last;
   logic [3:0]        note_q, note_nxt;
   logic [1:0]        oct_q, oct_nxt;
   logic [6:0]        led_q, led_nxt;
   logic              busy_nxt;

   assign key_rise   = keys & ~keys_q;
   assign sel_rise   = song_select & ~sel_q;
   assign mode_run   = (mode == MODE_AUTO) || (mode == MODE_LEARN);
   assign mode_q_run = (mode_q == MODE_AUTO) || (mode_q == MODE_LEARN);
   assign mode_chg   = (mode != mode_q);
   assign key_hit    = (prio_note(key_rise) == word_q[9:6]);
   assign word_nxt   = (state == S_WAIT_ROM) ? rom_data : word_q;
   assign play_len   = CNT_W'(BEAT_CYCLES) * CNT_W'(word_nxt[3:0]) - CNT_W'(1);
   assign base_nxt   = ADDR_W'(SONG_LEN * song_idx_nxt);
   assign slot_last  = ADDR_W'(SONG_LEN * song_idx + SONG_LEN - 1);

   always_comb begin
      song_idx_nxt = song_idx;
      song_chg     = 1'b0;
      if (sel_rise == 2'b01) begin
         song_idx_nxt = (song_idx == 2'(NUM_SONGS - 1)) ? 2'd0 : song_idx + 2'd1;
         song_chg     = 1'b1;
      end else if (sel_rise == 2'b10) begin
         song_idx_nxt = (song_idx == 2'd0) ? 2'(NUM_SONGS - 1) : song_idx - 2'd1;
         song_chg     = 1'b1;
      end
   end

   // Leaving a running mode drops to IDLE first, so the new mode always starts cleanly.
   always_comb begin
      state_nxt = state;
      if (!mode_run) begin
         state_nxt = S_IDLE;
      end else if (mode_chg && mode_q_run) begin
         state_nxt = S_IDLE;
      end else if (song_chg) begin
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_IDLE:     state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_WAIT_ROM;
            S_WAIT_ROM: begin
               if (rom_data[3:0] == 4'd0)
                  state_nxt = S_DONE;
               else if (mode == MODE_LEARN && rom_data[9:6] != 4'd0)
                  state_nxt = S_WAIT_KEY;
               else
                  state_nxt = S_PLAY;
            end
            S_WAIT_KEY: if (key_hit) state_nxt = S_PLAY;
            S_PLAY:     if (cnt == '0) state_nxt = S_GAP;
            S_GAP: begin
               if (cnt == '0) state_nxt = (rom_addr == slot_last) ? S_DONE : S_FETCH;
            end
            S_DONE:     state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      note_nxt = 4'd0;
      oct_nxt  = 2'd0;
      led_nxt  = 7'd0;
      busy_nxt = 1'b0;
      case (state_nxt)
         S_FETCH, S_WAIT_ROM, S_GAP: busy_nxt = 1'b1;
         S_WAIT_KEY: begin
            busy_nxt = 1'b1;
            led_nxt  = note_led(word_nxt[9:6]);
         end
         S_PLAY: begin
            busy_nxt = 1'b1;
            note_nxt = word_nxt[9:6];
            oct_nxt  = word_nxt[5:4];
            led_nxt  = note_led(word_nxt[9:6]);
         end
         default: busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         mode_q   <= 3'd0;
         keys_q   <= 7'd0;
         sel_q    <= 2'd0;
         song_idx <= 2'd0;
         rom_addr <= '0;
         note_q   <= 4'd0;
         oct_q    <= 2'd0;
         led_q    <= 7'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode;
         keys_q   <= keys;
         sel_q    <= song_select;
         song_idx <= song_idx_nxt;
         note_q   <= note_nxt;
         oct_q    <= oct_nxt;
         led_q    <= led_nxt;
         busy     <= busy_nxt;
         if (state_nxt == S_FETCH)
            rom_addr <= (state == S_GAP && !song_chg) ? rom_addr + ADDR_W'(1) : base_nxt;
      end
   end

   // Word and timer are always loaded before use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == S_WAIT_ROM) word_q <= rom_data;
      if (state_nxt == S_PLAY && state != S_PLAY)
         cnt <= play_len;
      else if (state_nxt == S_GAP && state != S_GAP)
         cnt <= CNT_W'(GAP_CYCLES - 1);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign free_on     = reset && (mode == MODE_FREE);
   assign note_out    = free_on ? prio_note(keys) : note_q;
   assign led_out     = free_on ? keys : led_q;
   assign octave_auto = free_on ? 2'd0 : oct_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a song-level trace model drives a per-cycle compare,
// with hand-computed literal checks at key points of each scenario.
module tb_song_sequencer;

   localparam int BEAT = 4;
   localparam int GAP  = 2;
   localparam int SLEN = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic [6:0] keys;
   logic [1:0] song_select;
   logic [7:0] rom_addr;
   logic [9:0] rom_data;
   logic [3:0] note_out;
   logic [1:0] octave_auto;
   logic [6:0] led_out;
   logic [1:0] song_idx;
   logic       busy;

   song_sequencer #(
      .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .NUM_SONGS(4), .SONG_LEN(SLEN), .ADDR_W(8)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .keys(keys), .song_select(song_select),
      .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
      .octave_auto(octave_auto), .led_out(led_out), .song_idx(song_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [9:0] rom [0:255];
   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct packed {
      logic [3:0] note;
      logic [1:0] oct;
      logic [6:0] led;
      logic       busy;
      logic [7:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   trace_pos = 0;
   logic [6:0] free_pats [0:4] = '{7'b0010100, 7'b0000000, 7'b1000000, 7'b0110000, 7'b1111111};

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   function automatic logic [9:0] w(input int n, input int o, input int d);
      return {4'(n), 2'(o), 4'(d)};
   endfunction

   function automatic int led_of(input int n);
      return (n == 0) ? 0 : (1 << (n - 1));
   endfunction

   function automatic int free_note(input logic [6:0] k);
      for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
      return 0;
   endfunction

   task automatic push(input int n, input int o, input int led, input int b, input int a, input int cnt);
      exp_t e;
      e.note = 4'(n); e.oct = 2'(o); e.led = 7'(led); e.busy = b[0]; e.addr = 8'(a);
      repeat (cnt) exp_q.push_back(e);
   endtask

   // Expected per-cycle outputs of a whole song, starting at its first fetch cycle.
   task automatic build_trace(input int idx, input bit learn, input int wait_cyc);
      int base;
      base = idx * SLEN;
      trace_pos = 0;
      for (int k = 0; k < SLEN; k++) begin
         int a;
         int n;
         int o;
         int d;
         a = base + k;
         n = int'(rom[a][9:6]);
         o = int'(rom[a][5:4]);
         d = int'(rom[a][3:0]);
         push(0, 0, 0, 1, a, 2);
         if (d == 0) begin
            push(0, 0, 0, 0, a, 3);
            return;
         end
         if (learn && n != 0) push(0, 0, led_of(n), 1, a, wait_cyc);
         push(n, o, led_of(n), 1, a, d * BEAT);
         push(0, 0, 0, 1, a, GAP);
      end
      push(0, 0, 0, 0, base + SLEN - 1, 3);
   endtask

   always @(negedge clk) begin : cmp
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("trace%0d_note", trace_pos), int'(note_out), int'(e.note));
         check($sformatf("trace%0d_oct", trace_pos), int'(octave_auto), int'(e.oct));
         check($sformatf("trace%0d_led", trace_pos), int'(led_out), int'(e.led));
         check($sformatf("trace%0d_busy", trace_pos), int'(busy), int'(e.busy));
         check($sformatf("trace%0d_addr", trace_pos), int'(rom_addr), int'(e.addr));
         trace_pos++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && exp_q.size() > 0; i++) tick(1);
      check("trace_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 10'd0;
      rom[0]  = w(3, 1, 2);
      rom[1]  = w(5, 2, 1);
      rom[8]  = w(4, 0, 1);
      rom[24] = w(6, 3, 1);
      for (int k = 0; k < 8; k++) rom[16 + k] = w((k % 7) + 1, k % 4, 1);

      reset = 1'b0; mode = 3'b000; keys = 7'd0; song_select = 2'b00;
      tick(3);
      reset = 1'b1;
      tick(1);
      check("rst_note", note_out, 0);
      check("rst_oct", octave_auto, 0);
      check("rst_led", led_out, 0);
      check("rst_busy", busy, 0);
      check("rst_idx", song_idx, 0);
      check("rst_addr", rom_addr, 0);

      // Free mode
      mode = 3'b100;
      for (int i = 0; i < 5; i++) begin
         keys = free_pats[i];
         #1;
         check("free_note", note_out, free_note(free_pats[i]));
         check("free_led", led_out, free_pats[i]);
         check("free_busy", busy, 0);
      end
      keys = 7'b0010100;
      #1;
      check("free_note_lit", note_out, 3);
      check("free_led_lit", led_out, 7'b0010100);
      keys = 7'd0;

      // Auto playback of song 0, entered straight from free mode
      tick(1);
      mode = 3'b010;
      tick(1);
      check("auto_fetch_addr", rom_addr, 0);
      check("auto_fetch_busy", busy, 1);
      build_trace(0, 1'b0, 0);
      tick(2);
      check("auto_n1_note", note_out, 3);
      check("auto_n1_oct", octave_auto, 1);
      check("auto_n1_led", led_out, 7'b0000100);
      tick(12);
      check("auto_n2_note", note_out, 5);
      check("auto_n2_oct", octave_auto, 2);
      tick(8);
      check("auto_done_busy", busy, 0);
      check("auto_done_note", note_out, 0);
      wait_drain();

      // Select next song while off: no playback starts
      mode = 3'b000;
      tick(1);
      song_select = 2'b01;
      tick(1);
      song_select = 2'b00;
      tick(1);
      check("next_idx", song_idx, 1);
      check("next_off_busy", busy, 0);

      // Learn mode on song 1
      mode = 3'b001;
      tick(1);
      check("learn_addr", rom_addr, 8);
      build_trace(1, 1'b1, 4);
      tick(3);
      keys = 7'b0000001;
      tick(1);
      check("learn_wrong_led", led_out, 7'b0001000);
      check("learn_wrong_note", note_out, 0);
      check("learn_wrong_busy", busy, 1);
      tick(1);
      keys = 7'b0001000;
      tick(1);
      check("learn_hit_note", note_out, 4);
      wait_drain();
      keys = 7'd0;

      // Both select lines rising together: no change, no restart
      song_select = 2'b11;
      tick(1);
      song_select = 2'b00;
      tick(1);
      check("both_idx", song_idx, 1);
      check("both_busy", busy, 0);

      // Back to song 0, then prev during playback wraps to song 3 and restarts
      mode = 3'b000;
      tick(1);
      song_select = 2'b10;
      tick(1);
      song_select = 2'b00;
      tick(1);
      check("prev_idx", song_idx, 0);
      mode = 3'b010;
      tick(5);
      check("pre_restart_note", note_out, 3);
      song_select = 2'b10;
      tick(1);
      check("wrap_prev_idx", song_idx, 3);
      check("wrap_prev_addr", rom_addr, 24);
      build_trace(3, 1'b0, 0);
      song_select = 2'b00;
      wait_drain();

      // Song slot without an end marker stops after its last word
      song_select = 2'b10;
      tick(1);
      check("full_idx", song_idx, 2);
      check("full_addr", rom_addr, 16);
      build_trace(2, 1'b0, 0);
      song_select = 2'b00;
      wait_drain();
      check("full_done_addr", rom_addr, 23);
      check("full_done_busy", busy, 0);

      // Reset in the middle of a note
      song_select = 2'b01;
      tick(1);
      song_select = 2'b00;
      tick(2);
      check("pre_reset_note", note_out, 6);
      reset = 1'b0;
      #1;
      check("mid_rst_note", note_out, 0);
      check("mid_rst_oct", octave_auto, 0);
      check("mid_rst_led", led_out, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_idx", song_idx, 0);
      check("mid_rst_addr", rom_addr, 0);
      mode = 3'b000;
      tick(1);
      reset = 1'b1;
      tick(2);
      check("post_rst_idx", song_idx, 0);
      check("post_rst_busy", busy, 0);

      // Mode changes mid-song
      mode = 3'b010;
      tick(3);
      check("mc_play_note", note_out, 3);
      mode = 3'b001;
      tick(1);
      check("mc_idle_note", note_out, 0);
      check("mc_idle_led", led_out, 0);
      check("mc_idle_busy", busy, 0);
      tick(3);
      check("mc_learn_led", led_out, 7'b0000100);
      check("mc_learn_busy", busy, 1);
      mode = 3'b011;
      tick(1);
      check("mc_bad_note", note_out, 0);
      check("mc_bad_led", led_out, 0);
      check("mc_bad_oct", octave_auto, 0);
      check("mc_bad_busy", busy, 0);

      // Wrap of song index in both directions
      mode = 3'b000;
      song_select = 2'b10;
      tick(1);
      song_select = 2'b00;
      tick(1);
      check("wrap_down_idx", song_idx, 3);
      song_select = 2'b01;
      tick(1);
      song_select = 2'b00;
      tick(1);
      check("wrap_up_idx", song_idx, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
